// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the oversampling UART receiver.
//               - uart_state_e : receiver FSM state encoding
//               - PARITY_EVEN / PARITY_ODD : parity sense constants
//               - calc_div()   : clocks per oversample tick (minimum 1)
//               - maj3()       : 2-of-3 majority vote
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Integer division truncates; a very fast line still gets one tick per clock.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Oversample tick generator. Emits a one-cycle tick every DIV
//               clocks while clr_i is low; clr_i holds the divider at zero so
//               the first tick after release lands DIV-1 clocks later.
// Ports       : clk     - system clock (rising edge)
//               rst_n   - synchronous active-low reset
//               clr_i   - synchronous clear / hold
//               tick_o  - one-cycle oversample strobe
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os
// Description : Oversampling UART receiver with 2-of-3 majority bit voting,
//               one-deep holding register with valid/ready handshake, frame,
//               parity and overrun reporting.
// Config      : define UART_RX_PARITY_EN to include the parity bit and check;
//               otherwise rx_parity_err is tied low.
// Ports       : clk, rst_n (sync, active low), rxd (async line, idles high)
//               rx_data/rx_valid/rx_ready - received payload handshake
//               rx_frame_err, rx_parity_err - flags qualified by rx_valid
//               rx_overrun - frame(s) dropped since last handshake
//               rx_busy    - FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int CLOCK_SPEED = 100_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    import uart_pkg::*;

    localparam int            DIV       = calc_div(CLOCK_SPEED, BAUD_RATE, OVERSAMPLE);
    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0      = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1      = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2      = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic                 rxd_meta_q, rxd_s_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 samp0_q, samp0_d, samp1_q, samp1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 oferr_q, oferr_d;
    logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    localparam logic      PAR_ODD = (PARITY_ODD != 0);
    logic                 perr_q, perr_d;
    logic                 operr_q, operr_d;
`endif

    logic tick, maj, mid, bit_end, hs, deliver;

    uart_baud_tick #(
        .DIV    (DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick)
    );

    // Third vote comes straight from the line on the decision tick.
    assign maj     = maj3(samp0_q, samp1_q, rxd_s_q);
    assign mid     = tick && (tick_cnt_q == T_S2);
    assign bit_end = tick && (tick_cnt_q == T_LAST);
    assign hs      = valid_q && rx_ready;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        samp0_d    = samp0_q;
        samp1_d    = samp1_q;
        shift_d    = shift_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        oferr_d    = oferr_q;
        ovr_d      = ovr_q;
        deliver    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d     = perr_q;
        operr_d    = operr_q;
`endif

        if (tick) begin
            if (tick_cnt_q == T_S0) samp0_d = rxd_s_q;
            if (tick_cnt_q == T_S1) samp1_d = rxd_s_q;
            tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                if (!rxd_s_q) begin
                    state_d    = ST_START;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_d     = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (mid && maj) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mid) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (mid) begin
                    perr_d = maj ^ (^shift_q) ^ PAR_ODD;
                end
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (mid) begin
                    if (!maj) ferr_d = 1'b1;
                    // Leave on the last mid-sample so the next start edge is
                    // seen even with a short stop bit from the far end.
                    if (stop_cnt_q == LAST_STOP) begin
                        deliver = 1'b1;
                        state_d = ferr_d ? ST_WAIT_HIGH : ST_IDLE;
                    end
                end else if (bit_end) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxd_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (hs) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                oferr_d = ferr_d;
`ifdef UART_RX_PARITY_EN
                operr_d = perr_d;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            samp0_q    <= 1'b0;
            samp1_q    <= 1'b0;
            shift_q    <= '0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            oferr_q    <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
            operr_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            samp0_q    <= samp0_d;
            samp1_q    <= samp1_d;
            shift_q    <= shift_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            oferr_q    <= oferr_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q     <= perr_d;
            operr_q    <= operr_d;
`endif
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = oferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = operr_q;
`else
    // Constant low; PARITY_ODD only has meaning when parity is compiled in.
    assign rx_parity_err = 1'b0 & (PARITY_ODD != 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_os
// Description : Directed self-checking bench for uart_rx_os at 16 clocks per
//               bit (DIV=1). Parity scenario active with UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int BIT_CLKS = 16;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         hs_cnt       = 0;
    logic [7:0] last_data    = 8'h00;
    logic       last_ferr    = 1'b0;
    logic       last_perr    = 1'b0;

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLOCK_SPEED (1_600_000),
        .BAUD_RATE   (100_000),
        .OVERSAMPLE  (16),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .PARITY_ODD  (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    // Record every accepted frame.
    always @(posedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            hs_cnt    <= hs_cnt + 1;
            last_data <= rx_data;
            last_ferr <= rx_frame_err;
            last_perr <= rx_parity_err;
        end
    end

    // One bit cell; glitch_at >= 0 inverts the line for that single clock.
    task automatic send_bit(input logic b, input int glitch_at);
        for (int i = 0; i < BIT_CLKS; i++) begin
            rxd = (i == glitch_at) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic par_flip,
                              input int g_bit, input int g_at);
        send_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], (i == g_bit) ? g_at : -1);
        end
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip, -1);
`else
        if (par_flip) $display("[TB] note: parity not compiled in, flip ignored");
`endif
        send_bit(stop_val, -1);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b want 00/0000", rx_data, rx_valid,
                     rx_frame_err, rx_parity_err, rx_overrun);
        end
        tests_run++;
        if (rx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b want 0", rx_busy);
        end
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_basic();
        int n0;
        rx_ready = 1'b1;
        n0 = hs_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, -1, 0);
        repeat (BIT_CLKS) @(negedge clk);
        tests_run++;
        if (hs_cnt - n0 !== 1) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d frames want 1", hs_cnt - n0);
        end
        tests_run++;
        if (last_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL basic_data: got %h want a5", last_data);
        end
        tests_run++;
        if ({last_ferr, last_perr} !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_flags: got %b%b want 00", last_ferr, last_perr);
        end
        tests_run++;
        if ({rx_valid, rx_overrun} !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_after: valid/ovr got %b%b want 00", rx_valid, rx_overrun);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int n0;
        rx_ready = 1'b1;
        n0 = hs_cnt;
        // 0x03 has even weight, so even parity expects 0; send 1.
        send_frame(8'h03, 1'b1, 1'b1, -1, 0);
        repeat (BIT_CLKS) @(negedge clk);
        tests_run++;
        if (hs_cnt - n0 !== 1 || last_data !== 8'h03) begin
            tests_failed++;
            $display("FAIL parity_data: got %0d frames data %h want 1 frame 03", hs_cnt - n0, last_data);
        end
        tests_run++;
        if (last_perr !== 1'b1) begin
            tests_failed++;
            $display("FAIL parity_err: got %b want 1", last_perr);
        end
        tests_run++;
        if (last_ferr !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_ferr: got %b want 0", last_ferr);
        end
    endtask
`endif

    task automatic test_frame_err();
        int n0;
        rx_ready = 1'b1;
        n0 = hs_cnt;
        send_frame(8'h55, 1'b0, 1'b0, -1, 0);
        rxd = 1'b0;
        repeat (40 * BIT_CLKS) @(negedge clk);
        tests_run++;
        if (hs_cnt - n0 !== 1 || last_data !== 8'h55) begin
            tests_failed++;
            $display("FAIL ferr_data: got %0d frames data %h want 1 frame 55", hs_cnt - n0, last_data);
        end
        tests_run++;
        if (last_ferr !== 1'b1) begin
            tests_failed++;
            $display("FAIL ferr_flag: got %b want 1", last_ferr);
        end
        tests_run++;
        if (rx_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ferr_wait_high: busy got %b want 1", rx_busy);
        end
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if (rx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ferr_release: busy got %b want 0", rx_busy);
        end
        send_frame(8'h12, 1'b1, 1'b0, -1, 0);
        repeat (BIT_CLKS) @(negedge clk);
        tests_run++;
        if (hs_cnt - n0 !== 2 || last_data !== 8'h12) begin
            tests_failed++;
            $display("FAIL ferr_next_data: got %0d frames data %h want 2 frames 12", hs_cnt - n0, last_data);
        end
        tests_run++;
        if (last_ferr !== 1'b0) begin
            tests_failed++;
            $display("FAIL ferr_next_flag: got %b want 0", last_ferr);
        end
    endtask

    task automatic test_overrun();
        int n0;
        rx_ready = 1'b0;
        n0 = hs_cnt;
        send_frame(8'h11, 1'b1, 1'b0, -1, 0);
        repeat (BIT_CLKS) @(negedge clk);
        send_frame(8'h22, 1'b1, 1'b0, -1, 0);
        repeat (BIT_CLKS) @(negedge clk);
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL ovr_hold: valid/data got %b/%h want 1/11", rx_valid, rx_data);
        end
        tests_run++;
        if (rx_overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_flag: got %b want 1", rx_overrun);
        end
        tests_run++;
        if (hs_cnt - n0 !== 0) begin
            tests_failed++;
            $display("FAIL ovr_no_hs: got %0d frames want 0", hs_cnt - n0);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({rx_valid, rx_overrun} !== 2'b00) begin
            tests_failed++;
            $display("FAIL ovr_clear: valid/ovr got %b%b want 00", rx_valid, rx_overrun);
        end
        tests_run++;
        if (hs_cnt - n0 !== 1 || last_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL ovr_taken: got %0d frames data %h want 1 frame 11", hs_cnt - n0, last_data);
        end
    endtask

    task automatic test_glitch();
        int n0;
        rx_ready = 1'b1;
        n0 = hs_cnt;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (rx_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_start: busy got %b want 1", rx_busy);
        end
        repeat (3 * BIT_CLKS) @(negedge clk);
        tests_run++;
        if (rx_busy !== 1'b0 || hs_cnt - n0 !== 0) begin
            tests_failed++;
            $display("FAIL glitch_false_start: busy %b frames %0d want 0 and 0", rx_busy, hs_cnt - n0);
        end
        // Single-clock spikes that land on one of the three votes.
        send_frame(8'h3C, 1'b1, 1'b0, 0, 8);
        repeat (BIT_CLKS) @(negedge clk);
        tests_run++;
        if (hs_cnt - n0 !== 1 || last_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL spike_low_bit: got %0d frames data %h want 1 frame 3c", hs_cnt - n0, last_data);
        end
        send_frame(8'h3C, 1'b1, 1'b0, 2, 9);
        repeat (BIT_CLKS) @(negedge clk);
        tests_run++;
        if (hs_cnt - n0 !== 2 || last_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL spike_high_bit: got %0d frames data %h want 2 frames 3c", hs_cnt - n0, last_data);
        end
    endtask

    task automatic test_reset_mid();
        int         n0;
        logic [7:0] d;
        rx_ready = 1'b1;
        n0 = hs_cnt;
        d  = 8'h5A;
        send_bit(1'b0, -1);
        for (int i = 0; i < 3; i++) send_bit(d[i], -1);
        rxd = d[3];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy} !== 13'h0000) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got %h/%b%b%b%b%b want 00/00000", rx_data, rx_valid,
                     rx_frame_err, rx_parity_err, rx_overrun, rx_busy);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        tests_run++;
        if (hs_cnt - n0 !== 0 || rx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_abandon: frames %0d busy %b want 0 and 0", hs_cnt - n0, rx_busy);
        end
        send_frame(8'h7E, 1'b1, 1'b0, -1, 0);
        repeat (BIT_CLKS) @(negedge clk);
        tests_run++;
        if (hs_cnt - n0 !== 1 || last_data !== 8'h7E) begin
            tests_failed++;
            $display("FAIL rstmid_next: got %0d frames data %h want 1 frame 7e", hs_cnt - n0, last_data);
        end
        tests_run++;
        if ({last_ferr, last_perr} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rstmid_flags: got %b%b want 00", last_ferr, last_perr);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
